// File: rtl/imm_gen_stage.sv
// Two-stage RV32I immediate generator with valid/ready on both sides and a saturating illegal-opcode counter.
// Define IMM_NEG_EN to add out_imm_neg, the registered two's complement of out_imm.
module imm_gen_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
`ifdef IMM_NEG_EN
    output logic [31:0]      out_imm_neg,
`endif
    output logic [CNT_W-1:0] ill_cnt
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    logic        s1_valid;
    logic [31:0] s1_instr;
    logic        s2_valid;
    fmt_e        s2_fmt;

    logic [31:0] dec_imm;
    fmt_e        dec_fmt;
    logic        dec_ill;

    logic s1_adv;
    logic accept;
    logic out_fire;

    // S1 may move on whenever S2 is empty or is being drained this cycle.
    assign s1_adv   = s1_valid & (~s2_valid | out_ready);
    assign in_ready = ~s1_valid | (~s2_valid | out_ready);
    assign accept   = in_valid & in_ready & ~flush;
    assign out_fire = s2_valid & out_ready;

    assign out_valid = s2_valid;
    assign out_fmt   = s2_fmt;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b1;
        unique case (s1_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                dec_imm = {{20{s1_instr[31]}}, s1_instr[31:20]};
                dec_fmt = FMT_I;
                dec_ill = 1'b0;
            end
            7'b0100011: begin
                dec_imm = {{20{s1_instr[31]}}, s1_instr[31:25], s1_instr[11:7]};
                dec_fmt = FMT_S;
                dec_ill = 1'b0;
            end
            7'b1100011: begin
                dec_imm = {{19{s1_instr[31]}}, s1_instr[31], s1_instr[7],
                           s1_instr[30:25], s1_instr[11:8], 1'b0};
                dec_fmt = FMT_B;
                dec_ill = 1'b0;
            end
            7'b0110111, 7'b0010111: begin
                dec_imm = {s1_instr[31:12], 12'b0};
                dec_fmt = FMT_U;
                dec_ill = 1'b0;
            end
            7'b1101111: begin
                dec_imm = {{11{s1_instr[31]}}, s1_instr[31], s1_instr[19:12],
                           s1_instr[20], s1_instr[30:21], 1'b0};
                dec_fmt = FMT_J;
                dec_ill = 1'b0;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_instr <= in_instr;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Result registers only load on advance, which keeps them stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            out_imm     <= '0;
            s2_fmt      <= FMT_NONE;
            out_illegal <= 1'b0;
`ifdef IMM_NEG_EN
            out_imm_neg <= '0;
`endif
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s1_adv) begin
            s2_valid    <= 1'b1;
            out_imm     <= dec_imm;
            s2_fmt      <= dec_fmt;
            out_illegal <= dec_ill;
`ifdef IMM_NEG_EN
            out_imm_neg <= ~dec_imm + 32'd1;
`endif
        end else if (out_fire) begin
            s2_valid <= 1'b0;
        end
    end

    // Counts delivered illegal results, including a delivery that coincides with flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt <= '0;
        end else if (out_fire && out_illegal && (ill_cnt != {CNT_W{1'b1}})) begin
            ill_cnt <= ill_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against an occupancy/age queue model and an arithmetic immediate decoder.
module tb_imm_gen_stage;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
`ifdef IMM_NEG_EN
    logic [31:0]      out_imm_neg;
`endif
    logic [CNT_W-1:0] ill_cnt;

    imm_gen_stage #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal),
`ifdef IMM_NEG_EN
        .out_imm_neg (out_imm_neg),
`endif
        .ill_cnt     (ill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoder built from shifts and masks on the whole word.
    function automatic int field(input logic [31:0] w, input int lo, input int n);
        return int'((w >> lo) & ((32'd1 << n) - 32'd1));
    endfunction

    function automatic void ref_dec(input logic [31:0] w, output logic [31:0] imm,
                                    output logic [2:0] fmt, output logic ill);
        int s;
        s   = $signed(w);
        imm = 32'd0;
        fmt = 3'd0;
        ill = 1'b0;
        case (w[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: begin imm = s >>> 20; fmt = 3'd1; end
            7'h23: begin imm = ((s >>> 25) <<< 5) | field(w, 7, 5); fmt = 3'd2; end
            7'h63: begin
                imm = ((s >>> 31) <<< 12) | (field(w, 7, 1) << 11) | (field(w, 25, 6) << 5)
                      | (field(w, 8, 4) << 1);
                fmt = 3'd3;
            end
            7'h37, 7'h17: begin imm = w & 32'hFFFF_F000; fmt = 3'd4; end
            7'h6F: begin
                imm = ((s >>> 31) <<< 20) | (field(w, 12, 8) << 12) | (field(w, 20, 1) << 11)
                      | (field(w, 21, 10) << 1);
                fmt = 3'd5;
            end
            default: ill = 1'b1;
        endcase
    endfunction

    // Model: queue of undelivered words tagged with the cycle they were accepted.
    typedef struct {
        logic [31:0] instr;
        int          acc;
    } item_t;

    item_t q[$];
    int    cyc   = 0;
    int    m_cnt = 0;

    always @(negedge clk) begin
        logic        exp_valid;
        logic        exp_ready;
        logic [31:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_ill;
        if (!rst_n) begin
            q.delete();
            m_cnt = 0;
        end else begin
            cyc++;
            exp_valid = (q.size() > 0) && (q[0].acc + 2 <= cyc);
            exp_ready = (q.size() < 2) || out_ready;
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            check("ill_cnt", 32'(ill_cnt), 32'(m_cnt));
            if (exp_valid) begin
                ref_dec(q[0].instr, e_imm, e_fmt, e_ill);
                check("out_imm", out_imm, e_imm);
                check("out_fmt", 32'(out_fmt), 32'(e_fmt));
                check("out_illegal", 32'(out_illegal), 32'(e_ill));
`ifdef IMM_NEG_EN
                check("out_imm_neg", out_imm_neg, 32'(-int'(e_imm)));
`endif
                if (out_ready) begin
                    void'(q.pop_front());
                    if (e_ill && m_cnt < CNT_MAX) m_cnt++;
                end
            end
            if (flush) q.delete();
            else if (in_valid && exp_ready) q.push_back('{instr: in_instr, acc: cyc});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [31:0] imm, input logic [2:0] fmt,
                           input logic ill);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_imm"}, out_imm, imm);
        check({name, "_fmt"}, 32'(out_fmt), 32'(fmt));
        check({name, "_ill"}, 32'(out_illegal), 32'(ill));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
        logic [31:0] r;
        int          k;
        r = $urandom();
        k = $urandom_range(0, 11);
        if (k < 10) return {r[31:7], ops[k]};
        return r;
    endfunction

    logic [31:0] bp [4] = '{32'h0050_0113, 32'h8000_0037, 32'hFFDF_F06F, 32'h00A1_2423};

    initial begin
        int    idx;
        logic  rdy;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_imm", out_imm, 32'd0);
        check("rst_out_fmt", 32'(out_fmt), 32'd0);
        check("rst_out_ill", 32'(out_illegal), 32'd0);
        check("rst_ill_cnt", 32'(ill_cnt), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // addi x1,x0,-1 with a two-cycle latency
        step(); in_valid = 1'b1; in_instr = 32'hFFF0_0093; out_ready = 1'b1;
        step(); in_valid = 1'b0;
        step(); chk_out("addi", 32'hFFFF_FFFF, 3'd1, 1'b0);
`ifdef IMM_NEG_EN
        check("addi_neg", out_imm_neg, 32'h0000_0001);
`endif
        step(); check("addi_drained", 32'(out_valid), 32'd0);

        // S, B, U back to back
        step(); in_valid = 1'b1; in_instr = 32'hFE11_2E23;
        step(); in_instr = 32'h0000_0863;
        step(); chk_out("sw_s", 32'hFFFF_FFFC, 3'd2, 1'b0); in_instr = 32'h1234_50B7;
        step(); chk_out("beq_b", 32'h0000_0010, 3'd3, 1'b0); in_valid = 1'b0;
        step(); chk_out("lui_u", 32'h1234_5000, 3'd4, 1'b0);
        step(); check("sweep_drained", 32'(out_valid), 32'd0);

        // Backpressure: two accepts then stall; order checked by the model
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_instr = bp[idx];
            #1 rdy = in_ready;
            step();
            if (rdy) idx++;
        end
        check("bp_accepts", 32'(idx), 32'd2);
        check("bp_stall_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            in_valid = 1'b1; in_instr = bp[idx];
            #1 rdy = in_ready;
            step();
            if (rdy) idx++;
        end
        check("bp_all_accepted", 32'(idx), 32'd4);
        in_valid = 1'b0;
        repeat (4) step();

        // Flush with both stages full and a word presented in the flush cycle
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000_007F;
        step();
        step(); in_instr = 32'hFFF0_0093; flush = 1'b1;
        check("pre_flush_valid", 32'(out_valid), 32'd1);
        check("pre_flush_ill", 32'(out_illegal), 32'd1);
        step(); flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_cnt", 32'(ill_cnt), 32'd0);
        step(); step();
        check("flush_dropped", 32'(out_valid), 32'd0);

        // Illegal opcode 17 times saturates the 4-bit counter
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0000_007F;
        repeat (17) step();
        in_valid = 1'b0;
        repeat (3) step();
        check("sat_cnt", 32'(ill_cnt), 32'd15);
        step();
        check("sat_hold", 32'(ill_cnt), 32'd15);

        // Randomized traffic with one asynchronous reset between edges
        for (int i = 0; i < 2000; i++) begin
            step();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_instr  = rand_instr();
            if (i == 900) begin
                #2 rst_n = 1'b0;
                #1;
                check("arst_out_valid", 32'(out_valid), 32'd0);
                check("arst_ill_cnt", 32'(ill_cnt), 32'd0);
                check("arst_in_ready", 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                flush    = 1'b0;
                @(posedge clk);
                #3 rst_n = 1'b1;
            end
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
